// File: rtl/fifo_write_feeder.sv
// Stream-to-FIFO write feeder: a 2-entry skid buffer drains into a memory core
// while tracking the core's occupancy so writes never overrun the configured depth.
module fifo_write_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [CNT_WIDTH-1:0]  depth,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  wen_in,
  input  logic                  rd_done,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]  credit,
  output logic                  core_full,
  output logic                  underflow_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic                  underflow_q, underflow_d;

  logic                  run;
  logic                  occ_below;
  logic                  issue;
  logic                  accept;
  logic [1:0]            cnt_after_issue;

  // Handshake and write strobe come only from registered state plus clk_en/flush,
  // so upstream never sees a combinational path from rd_done or in_valid.
  always_comb begin
    run       = clk_en && !flush;
    occ_below = occ_q < depth;
    issue     = run && (buf_cnt_q != 2'd0) && occ_below;
    in_ready  = run && (buf_cnt_q != 2'd2);
    accept    = in_valid && in_ready;
    wen_in    = issue;
    data_in   = (buf_cnt_q != 2'd0) ? head_q : '0;
    occupancy = occ_q;
    core_full = !occ_below;
    credit    = occ_below ? (depth - occ_q) : '0;
    underflow_err = underflow_q;
  end

  // NOTE: every variable gets a default before any branch; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    buf_cnt_d       = buf_cnt_q;
    occ_d           = occ_q;
    underflow_d     = underflow_q;
    cnt_after_issue = buf_cnt_q - {1'b0, issue};

    if (clk_en && flush) begin
      buf_cnt_d = 2'd0;
      occ_d     = '0;
      head_d    = '0;
      tail_d    = '0;
    end else if (clk_en) begin
      if (issue) head_d = tail_q;
      // A new word lands in head only when head is vacant after this cycle's issue.
      if (accept) begin
        if (cnt_after_issue == 2'd0) head_d = in_data;
        else                         tail_d = in_data;
      end
      buf_cnt_d = cnt_after_issue + {1'b0, accept};

      unique case ({issue, rd_done})
        2'b10: occ_d = occ_q + CNT_ONE;
        2'b01: begin
          if (occ_q == '0) underflow_d = 1'b1;
          else             occ_d       = occ_q - CNT_ONE;
        end
        // The word written this cycle covers the one read out, even from empty.
        2'b11: if (occ_q == '0) occ_d = CNT_ONE;
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments; the payload registers are reset too so
  // data_in is deterministic after reset rather than merely masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_cnt_q   <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_feeder.sv
// Directed bench for fifo_write_feeder: each scenario task drives fixed vectors and
// compares outputs against hand-derived expectations, sampled 2 time units after clk rises.
module tb_fifo_write_feeder;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          flush;
  logic [CW-1:0] depth;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          wen_in;
  logic          rd_done;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] credit;
  logic          core_full;
  logic          underflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_write_feeder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .depth(depth),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .wen_in(wen_in), .rd_done(rd_done), .occupancy(occupancy), .credit(credit),
    .core_full(core_full), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; clk_en = 1'b0; flush = 1'b0; in_valid = 1'b0; rd_done = 1'b0; in_data = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_en = 1'b0; flush = 1'b0; in_valid = 1'b0; rd_done = 1'b0; in_data = '0;
    depth = 16'd4;
    #2;
    n_checks++; if (wen_in !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %0b want 0", wen_in); end
    n_checks++; if (data_in !== 16'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", data_in); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", in_ready); end
    n_checks++; if (occupancy !== 16'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++; if (credit !== 16'd4) begin n_fail++; $display("FAIL reset_credit got %0d want 4", credit); end
    n_checks++; if (core_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", core_full); end
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_uf got %0b want 0", underflow_err); end
    depth = 16'd0;
    #1;
    n_checks++; if (core_full !== 1'b1) begin n_fail++; $display("FAIL reset_full_d0 got %0b want 1", core_full); end
    n_checks++; if (credit !== 16'd0) begin n_fail++; $display("FAIL reset_credit_d0 got %0d want 0", credit); end
    next_cycle();
    reset = 1'b1;
  endtask

  // depth=4, values 1..6 offered back to back, no reads.
  task automatic test_fill();
    logic       e_wen [7] = '{0, 1, 1, 1, 1, 0, 0};
    logic [15:0] e_dat [7] = '{0, 1, 2, 3, 4, 5, 5};
    logic       e_rdy [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [15:0] e_occ [7] = '{0, 0, 1, 2, 3, 4, 4};
    apply_reset();
    depth = 16'd4; clk_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 6);
      in_data  = (c < 6) ? DW'(c + 1) : '0;
      #1;
      n_checks++; if (wen_in !== e_wen[c]) begin n_fail++; $display("FAIL fill_wen c%0d got %0b want %0b", c, wen_in, e_wen[c]); end
      n_checks++; if (data_in !== e_dat[c]) begin n_fail++; $display("FAIL fill_data c%0d got %0d want %0d", c, data_in, e_dat[c]); end
      n_checks++; if (in_ready !== e_rdy[c]) begin n_fail++; $display("FAIL fill_ready c%0d got %0b want %0b", c, in_ready, e_rdy[c]); end
      n_checks++; if (occupancy !== e_occ[c]) begin n_fail++; $display("FAIL fill_occ c%0d got %0d want %0d", c, occupancy, e_occ[c]); end
      if (c < 6) next_cycle();
    end
    n_checks++; if (core_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", core_full); end
    n_checks++; if (credit !== 16'd0) begin n_fail++; $display("FAIL fill_credit got %0d want 0", credit); end
    next_cycle();
  endtask

  // Continues from test_fill: buffer holds 5,6 and the core is full.
  task automatic test_rd_done();
    rd_done = 1'b1;
    #1;
    n_checks++; if (wen_in !== 1'b0) begin n_fail++; $display("FAIL rd_wen0 got %0b want 0", wen_in); end
    next_cycle();
    rd_done = 1'b0;
    #1;
    n_checks++; if (wen_in !== 1'b1) begin n_fail++; $display("FAIL rd_wen1 got %0b want 1", wen_in); end
    n_checks++; if (data_in !== 16'd5) begin n_fail++; $display("FAIL rd_data5 got %0d want 5", data_in); end
    n_checks++; if (occupancy !== 16'd3) begin n_fail++; $display("FAIL rd_occ3 got %0d want 3", occupancy); end
    n_checks++; if (credit !== 16'd1) begin n_fail++; $display("FAIL rd_credit1 got %0d want 1", credit); end
    next_cycle();
    #1;
    n_checks++; if (occupancy !== 16'd4) begin n_fail++; $display("FAIL rd_occ4 got %0d want 4", occupancy); end
    n_checks++; if (credit !== 16'd0) begin n_fail++; $display("FAIL rd_credit0 got %0d want 0", credit); end
    n_checks++; if (data_in !== 16'd6) begin n_fail++; $display("FAIL rd_data6 got %0d want 6", data_in); end
    n_checks++; if (wen_in !== 1'b0) begin n_fail++; $display("FAIL rd_wen_stall got %0b want 0", wen_in); end
  endtask

  // Read and pending write in the same cycle, then read-from-empty covered by an issue.
  task automatic test_simultaneous();
    logic        v_val [6] = '{1, 1, 1, 0, 0, 0};
    logic [15:0] v_dat [6] = '{1, 2, 3, 0, 0, 0};
    logic        v_rd  [6] = '{0, 0, 0, 1, 0, 0};
    logic        e_wen [6] = '{0, 1, 1, 0, 1, 0};
    logic [15:0] e_occ [6] = '{0, 0, 1, 2, 1, 2};
    logic [15:0] e_dat [6] = '{0, 1, 2, 3, 3, 0};
    apply_reset();
    depth = 16'd2; clk_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = v_val[c]; in_data = v_dat[c]; rd_done = v_rd[c];
      #1;
      n_checks++; if (wen_in !== e_wen[c]) begin n_fail++; $display("FAIL sim_wen c%0d got %0b want %0b", c, wen_in, e_wen[c]); end
      n_checks++; if (occupancy !== e_occ[c]) begin n_fail++; $display("FAIL sim_occ c%0d got %0d want %0d", c, occupancy, e_occ[c]); end
      n_checks++; if (data_in !== e_dat[c]) begin n_fail++; $display("FAIL sim_data c%0d got %0d want %0d", c, data_in, e_dat[c]); end
      n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL sim_uf c%0d got %0b want 0", c, underflow_err); end
      next_cycle();
    end
    apply_reset();
    depth = 16'd2; clk_en = 1'b1;
    in_valid = 1'b1; in_data = 16'd7;
    next_cycle();
    in_valid = 1'b0; rd_done = 1'b1;
    #1;
    n_checks++; if (wen_in !== 1'b1 || data_in !== 16'd7) begin n_fail++; $display("FAIL sim_empty_issue wen=%0b data=%0d want wen=1 data=7", wen_in, data_in); end
    next_cycle();
    rd_done = 1'b0;
    #1;
    n_checks++; if (occupancy !== 16'd1) begin n_fail++; $display("FAIL sim_empty_occ got %0d want 1", occupancy); end
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL sim_empty_uf got %0b want 0", underflow_err); end
  endtask

  // Two words buffered with occupancy 3, then a one-cycle flush, then underflow stickiness.
  task automatic test_flush_underflow();
    apply_reset();
    depth = 16'd3; clk_en = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = DW'(11 + c);
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (occupancy !== 16'd3) begin n_fail++; $display("FAIL fl_pre_occ got %0d want 3", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_pre_ready got %0b want 0", in_ready); end
    n_checks++; if (data_in !== 16'd14) begin n_fail++; $display("FAIL fl_pre_data got %0d want 14", data_in); end
    next_cycle();
    flush = 1'b1;
    #1;
    n_checks++; if (wen_in !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_during wen=%0b ready=%0b want 0 0", wen_in, in_ready); end
    next_cycle();
    flush = 1'b0; in_valid = 1'b1; in_data = 16'd99;
    #1;
    n_checks++; if (occupancy !== 16'd0) begin n_fail++; $display("FAIL fl_post_occ got %0d want 0", occupancy); end
    n_checks++; if (data_in !== 16'd0 || wen_in !== 1'b0) begin n_fail++; $display("FAIL fl_post_empty data=%0d wen=%0b want 0 0", data_in, wen_in); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_post_ready got %0b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_checks++; if (wen_in !== 1'b1 || data_in !== 16'd99) begin n_fail++; $display("FAIL fl_new_word wen=%0b data=%0d want 1 99", wen_in, data_in); end
    next_cycle();
    rd_done = 1'b1;
    #1;
    n_checks++; if (occupancy !== 16'd1 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_pre occ=%0d uf=%0b want 1 0", occupancy, underflow_err); end
    next_cycle();
    #1;
    n_checks++; if (occupancy !== 16'd0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_last occ=%0d uf=%0b want 0 0", occupancy, underflow_err); end
    next_cycle();
    rd_done = 1'b0;
    #1;
    n_checks++; if (occupancy !== 16'd0 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_set occ=%0d uf=%0b want 0 1", occupancy, underflow_err); end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    #1;
    n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %0b want 1", underflow_err); end
    reset = 1'b0;
    #1;
    n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_reset got %0b want 0", underflow_err); end
  endtask

  // Five disabled cycles with valid and read asserted must change nothing.
  task automatic test_clk_en();
    apply_reset();
    depth = 16'd1; clk_en = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = DW'(c + 1);
      next_cycle();
    end
    clk_en = 1'b0; in_valid = 1'b1; in_data = 16'd77; rd_done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0 || wen_in !== 1'b0) begin n_fail++; $display("FAIL ce_hold c%0d ready=%0b wen=%0b want 0 0", c, in_ready, wen_in); end
      n_checks++; if (occupancy !== 16'd1 || data_in !== 16'd2) begin n_fail++; $display("FAIL ce_state c%0d occ=%0d data=%0d want 1 2", c, occupancy, data_in); end
      next_cycle();
    end
    clk_en = 1'b1; in_valid = 1'b0; rd_done = 1'b0;
    #1;
    n_checks++; if (occupancy !== 16'd1 || data_in !== 16'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ce_resume occ=%0d data=%0d ready=%0b want 1 2 0", occupancy, data_in, in_ready); end
    rd_done = 1'b1;
    next_cycle();
    rd_done = 1'b0;
    #1;
    n_checks++; if (wen_in !== 1'b1 || data_in !== 16'd2) begin n_fail++; $display("FAIL ce_word2 wen=%0b data=%0d want 1 2", wen_in, data_in); end
    next_cycle();
    rd_done = 1'b1;
    #1;
    n_checks++; if (wen_in !== 1'b0 || data_in !== 16'd3 || occupancy !== 16'd1) begin n_fail++; $display("FAIL ce_word3_wait wen=%0b data=%0d occ=%0d want 0 3 1", wen_in, data_in, occupancy); end
    next_cycle();
    rd_done = 1'b0;
    #1;
    n_checks++; if (wen_in !== 1'b1 || data_in !== 16'd3) begin n_fail++; $display("FAIL ce_word3 wen=%0b data=%0d want 1 3", wen_in, data_in); end
  endtask

  // Depth lowered below occupancy: writes stall, occupancy is not clipped.
  task automatic test_depth_drop();
    apply_reset();
    depth = 16'd4; clk_en = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = DW'(c + 1);
      next_cycle();
    end
    in_valid = 1'b0; depth = 16'd2;
    #1;
    n_checks++; if (wen_in !== 1'b0 || occupancy !== 16'd3) begin n_fail++; $display("FAIL dd_stall wen=%0b occ=%0d want 0 3", wen_in, occupancy); end
    n_checks++; if (core_full !== 1'b1 || credit !== 16'd0) begin n_fail++; $display("FAIL dd_flags full=%0b credit=%0d want 1 0", core_full, credit); end
    rd_done = 1'b1;
    next_cycle();
    #1;
    n_checks++; if (wen_in !== 1'b0 || occupancy !== 16'd2) begin n_fail++; $display("FAIL dd_at_depth wen=%0b occ=%0d want 0 2", wen_in, occupancy); end
    next_cycle();
    rd_done = 1'b0;
    #1;
    n_checks++; if (wen_in !== 1'b1 || data_in !== 16'd4 || occupancy !== 16'd1) begin n_fail++; $display("FAIL dd_resume wen=%0b data=%0d occ=%0d want 1 4 1", wen_in, data_in, occupancy); end
  endtask

  // depth=0 fills the buffer and blocks; then a mid-burst reset discards it.
  task automatic test_depth_zero_and_reset();
    apply_reset();
    depth = 16'd0; clk_en = 1'b1; in_valid = 1'b1; in_data = 16'd1;
    #1;
    n_checks++; if (in_ready !== 1'b1 || wen_in !== 1'b0) begin n_fail++; $display("FAIL dz_c0 ready=%0b wen=%0b want 1 0", in_ready, wen_in); end
    n_checks++; if (core_full !== 1'b1 || credit !== 16'd0) begin n_fail++; $display("FAIL dz_flags full=%0b credit=%0d want 1 0", core_full, credit); end
    next_cycle();
    in_data = 16'd2;
    #1;
    n_checks++; if (in_ready !== 1'b1 || wen_in !== 1'b0 || data_in !== 16'd1) begin n_fail++; $display("FAIL dz_c1 ready=%0b wen=%0b data=%0d want 1 0 1", in_ready, wen_in, data_in); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0 || wen_in !== 1'b0 || data_in !== 16'd1) begin n_fail++; $display("FAIL dz_full ready=%0b wen=%0b data=%0d want 0 0 1", in_ready, wen_in, data_in); end
    reset = 1'b0;
    #1;
    n_checks++; if (data_in !== 16'd0) begin n_fail++; $display("FAIL mid_reset_data got %0d want 0", data_in); end
    next_cycle();
    reset = 1'b1; depth = 16'd4; in_valid = 1'b1; in_data = 16'd50;
    #1;
    n_checks++; if (wen_in !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_idle wen=%0b ready=%0b want 0 1", wen_in, in_ready); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_checks++; if (wen_in !== 1'b1 || data_in !== 16'd50) begin n_fail++; $display("FAIL mid_reset_first wen=%0b data=%0d want 1 50", wen_in, data_in); end
    next_cycle();
    #1;
    n_checks++; if (wen_in !== 1'b0 || data_in !== 16'd0 || occupancy !== 16'd1) begin n_fail++; $display("FAIL mid_reset_after wen=%0b data=%0d occ=%0d want 0 0 1", wen_in, data_in, occupancy); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_rd_done();
    test_simultaneous();
    test_flush_underflow();
    test_clk_en();
    test_depth_drop();
    test_depth_zero_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_feeder.md
FIFO_WRITE_FEEDER -- requirements
Module: fifo_write_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the stream and write data.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of depth, occupancy and credit.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 clk_en  input  1  SHALL be the global enable; when low, all state holds.
REQ-006 flush  input  1  SHALL be a synchronous clear of the buffer and occupancy.
REQ-007 depth  input  CNT_WIDTH  SHALL be the configured FIFO capacity of the downstream memory core.
REQ-008 in_data  input  DATA_WIDTH  SHALL be the upstream stream payload.
REQ-009 in_valid  input  1  SHALL be the upstream payload-valid signal.
REQ-010 in_ready  output  1  SHALL mean the feeder accepts in_data this cycle.
REQ-011 data_in  output  DATA_WIDTH  SHALL be the write data to the memory core.
REQ-012 wen_in  output  1  SHALL be the write strobe to the memory core.
REQ-013 rd_done  input  1  SHALL mean one word left the memory core this cycle (ren and valid_out both high).
REQ-014 occupancy  output  CNT_WIDTH  SHALL be the count of words resident in the memory core.
REQ-015 credit  output  CNT_WIDTH  SHALL be depth-occupancy when occupancy<depth, else 0.
REQ-016 core_full  output  1  SHALL be high when occupancy>=depth.
REQ-017 underflow_err  output  1  SHALL be a sticky flag for rd_done while occupancy==0.

Function
REQ-018 The feeder SHALL contain a 2-entry skid buffer (head, tail) with registered count buf_cnt in {0,1,2}.
REQ-019 in_ready SHALL equal clk_en && !flush && buf_cnt<2; it SHALL depend only on registered state plus clk_en and flush.
REQ-020 Accept SHALL occur when in_valid && in_ready; the payload SHALL be written to head if head is empty after this cycle's issue, else to tail.
REQ-021 data_in SHALL always present the head entry; it SHALL be 0 when buf_cnt==0.
REQ-022 wen_in SHALL equal clk_en && !flush && buf_cnt>0 && occupancy<depth (combinational).
REQ-023 Latency SHALL be 1 cycle minimum: a word accepted in cycle N SHALL first drive wen_in in cycle N+1.
REQ-024 On issue, tail SHALL shift to head; with simultaneous accept and issue, buf_cnt SHALL be unchanged and order SHALL be preserved.
REQ-025 Occupancy update SHALL be: +1 on issue only; -1 on rd_done only; unchanged on both or neither.
REQ-026 On rd_done with occupancy==0 and no issue, occupancy SHALL stay 0 and underflow_err SHALL set; with a simultaneous issue, occupancy SHALL become 1 and no error SHALL be flagged.
REQ-027 Occupancy SHALL never exceed depth through issues; it SHALL never wrap.
REQ-028 With depth==0, wen_in SHALL stay low, and the buffer SHALL fill to 2 and then deassert in_ready.
REQ-029 If depth drops below occupancy at run time, writes SHALL stall until occupancy<depth; occupancy SHALL NOT be clipped.
REQ-030 When clk_en is low, no accept, issue or occupancy change SHALL occur; rd_done SHALL be ignored.
REQ-031 When flush is high with clk_en high, buf_cnt and occupancy SHALL clear to 0 next cycle; underflow_err SHALL be retained; wen_in and in_ready SHALL be low that cycle.
REQ-032 Data order on data_in SHALL equal the accept order on in_data with no loss or duplication.

Reset
REQ-033 When reset is low, the block SHALL asynchronously clear buf_cnt, occupancy, underflow_err, head and tail to 0.
REQ-034 From reset, outputs SHALL be: wen_in=0, data_in=0, in_ready=0, occupancy=0, core_full=(depth==0), credit=depth, underflow_err=0.
REQ-035 Reset asserted mid-burst SHALL discard buffered words; after release, the first accepted word SHALL be the next one issued.
REQ-036 Reset deassertion SHALL be synchronised externally; the block SHALL assume a clean release relative to clk.

Verification
REQ-037 depth=4, in_valid held high with values 1..6, rd_done=0 -> wen_in for values 1..4 on cycles 1..4; occupancy=4, core_full=1; buffer holds 5,6; in_ready=0.
REQ-038 Continuing REQ-037, one rd_done pulse -> next cycle value 5 written, occupancy stays 4, credit=0.
REQ-039 depth=2, occupancy=2, rd_done and a pending word in the same cycle -> occupancy goes 1 then 2; wen_in fires once; no error.
REQ-040 occupancy=0, rd_done=1, no buffered word -> underflow_err=1 and sticky through flush; cleared only by reset.
REQ-041 Two words buffered, occupancy=3, flush=1 for 1 cycle -> buf_cnt=0, occupancy=0, wen_in=0 during flush; the next accepted word is written after 1 cycle.
REQ-042 clk_en=0 for 5 cycles with in_valid=1 and rd_done=1 -> no state change and in_ready=0; on resuming, order and counts are intact.
